// File: rtl/jtag_debug_cmd_dispatch_if.sv
// Signal bundle between the TCK-side JTAG logic, the debug core and the
// system-clock command dispatcher.
//
// Handshake: vs_udr and vs_uir are level strobes from the TCK domain. The
// dispatcher acts only on their synchronised rising edges. ir_in and sr
// must stay stable while vs_udr is high. take_action and take_no_action are
// one-cycle pulses. For commands that wait for an acknowledge, the target
// answers with a single-cycle cmd_ack pulse while busy is high. cmd_ack
// seen at any other time is ignored.
interface jtag_debug_cmd_dispatch_if #(
   parameter int DATA_W = 38,
   parameter int IR_W   = 2
);
   localparam int NCMD = 2**IR_W;

   logic              vs_udr;
   logic              vs_uir;
   logic [IR_W-1:0]   ir_in;
   logic [DATA_W-1:0] sr;
   logic              cmd_ack;
   logic              status_clr;
   logic [DATA_W-1:0] jdo;
   logic [IR_W-1:0]   cmd_code;
   logic [NCMD-1:0]   take_action;
   logic [NCMD-1:0]   take_no_action;
   logic              ir_update;
   logic              busy;
   logic              overrun;
   logic              timeout;

   modport master (
      output vs_udr, vs_uir, ir_in, sr, cmd_ack, status_clr,
      input  jdo, cmd_code, take_action, take_no_action, ir_update,
             busy, overrun, timeout
   );

   modport slave (
      input  vs_udr, vs_uir, ir_in, sr, cmd_ack, status_clr,
      output jdo, cmd_code, take_action, take_no_action, ir_update,
             busy, overrun, timeout
   );
endinterface

// File: rtl/jtag_debug_cmd_dispatch.sv
// System-clock-side JTAG debug command dispatcher. Synchronises the TCK
// update strobes, latches the command word on update-DR and issues one
// one-hot pulse per command. Commands flagged in ACK_MASK then hold busy
// until cmd_ack arrives, until an update-IR aborts them or until the
// timeout expires. Dropped update-DR events and expired waits are recorded
// as sticky status bits.
module jtag_debug_cmd_dispatch #(
   parameter int                   DATA_W      = 38,
   parameter int                   IR_W        = 2,
   parameter int                   SYNC_STAGES = 2,
   parameter int                   ACT_BIT     = 37,
   parameter logic [(2**IR_W)-1:0] ACK_MASK    = 4'b0011,
   parameter int                   TIMEOUT_CYC = 1023
) (
   input  logic                       clk,
   input  logic                       reset_n,
   jtag_debug_cmd_dispatch_if.slave   bus,
   output logic [1:0]                 dbg_state
);

   localparam int NCMD  = 2**IR_W;
   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
   logic              udr_dly, uir_dly;
   logic              udr_rise, uir_rise;
   logic [DATA_W-1:0] jdo_q;
   logic [IR_W-1:0]   cmd_code_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              overrun_q, timeout_q;
   logic              load, cnt_clr, cnt_inc, set_ov, set_to;
   logic [NCMD-1:0]   cmd_onehot;

   // Synchronise both TCK strobes and keep one delayed copy for edge detect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync <= '0;
         uir_sync <= '0;
         udr_dly  <= 1'b0;
         uir_dly  <= 1'b0;
      end else begin
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
         udr_dly  <= udr_sync[SYNC_STAGES-1];
         uir_dly  <= uir_sync[SYNC_STAGES-1];
      end
   end

   assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_dly;
   assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_dly;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and datapath controls. An ack wins over an abort, and
   // both win over the timeout, so a late ack never reports a timeout.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      set_ov  = 1'b0;
      set_to  = 1'b0;
      case (state_q)
         IDLE: begin
            if (udr_rise) begin
               load    = 1'b1;
               state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            cnt_clr = 1'b1;
            state_d = ACK_MASK[cmd_code_q] ? WAIT_ACK : IDLE;
         end
         WAIT_ACK: begin
            if (bus.cmd_ack) begin
               state_d = IDLE;
            end else if (uir_rise) begin
               state_d = IDLE;
            end else if (TIMEOUT_CYC > 0) begin
               if (cnt_q == CNT_LAST) begin
                  set_to  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (udr_rise && (state_q != IDLE)) set_ov = 1'b1;
   end

   // Command latch: holds until the next accepted update-DR.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo_q      <= '0;
         cmd_code_q <= '0;
      end else if (load) begin
         jdo_q      <= bus.sr;
         cmd_code_q <= bus.ir_in;
      end
   end

   // Ack-wait counter. It stops at CNT_LAST, so it never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     cnt_q <= '0;
      else if (cnt_clr) cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
   end

   // Sticky status. A set in the same cycle as status_clr wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (set_ov)              overrun_q <= 1'b1;
         else if (bus.status_clr) overrun_q <= 1'b0;
         if (set_to)              timeout_q <= 1'b1;
         else if (bus.status_clr) timeout_q <= 1'b0;
      end
   end

   assign cmd_onehot         = NCMD'(1) << cmd_code_q;
   assign bus.take_action    = (state_q == DISPATCH && jdo_q[ACT_BIT])  ? cmd_onehot : '0;
   assign bus.take_no_action = (state_q == DISPATCH && !jdo_q[ACT_BIT]) ? cmd_onehot : '0;
   assign bus.jdo            = jdo_q;
   assign bus.cmd_code       = cmd_code_q;
   assign bus.ir_update      = uir_rise;
   assign bus.busy           = (state_q != IDLE);
   assign bus.overrun        = overrun_q;
   assign bus.timeout        = timeout_q;
   assign dbg_state          = state_q;

endmodule

// File: doc/jtag_debug_cmd_dispatch.md
Name: jtag_debug_cmd_dispatch

Overview:
- System-clock-side command dispatcher for the on-chip debug JTAG path.
- Receives update-DR/update-IR strobes, the IR code and the shift-register snapshot, all from the TCK domain. Synchronises the strobes, latches the command word, and issues one-hot take_action / take_no_action pulses per IR code.
- Generalises the fixed 2-bit/38-bit debug sysclk logic: parametrised IR/data width, per-command acknowledge handshake, timeout, and overrun/abort status for the debug core.

Parameters:
- DATA_W, 38, width of sr/jdo.
- IR_W, 2, IR code width; number of commands NCMD = 2**IR_W.
- SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir; legal values >= 2.
- ACT_BIT, 37, jdo bit selecting action vs no-action; must be < DATA_W.
- ACK_MASK, 4'b0011, NCMD bits; bit k=1 means command k waits for cmd_ack.
- TIMEOUT_CYC, 1023, ack wait limit in clk cycles; 0 = no timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- vs_udr  in  1  update-DR strobe, TCK domain, asynchronous to clk.
- vs_uir  in  1  update-IR strobe, TCK domain, asynchronous to clk.
- ir_in  in  IR_W  IR code; stable while vs_udr is high.
- sr  in  DATA_W  shift-register snapshot; stable while vs_udr is high.
- cmd_ack  in  1  target completion strobe.
- status_clr  in  1  clears overrun/timeout.
- jdo  out  DATA_W  latched command data.
- cmd_code  out  IR_W  latched IR code.
- take_action  out  NCMD  one-hot action pulse.
- take_no_action  out  NCMD  one-hot no-action pulse.
- ir_update  out  1  one-cycle pulse per IR update.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky: update-DR dropped.
- timeout  out  1  sticky: ack wait expired.

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous, active-low.
- Reset: all outputs 0, all synchroniser/edge flops 0, state IDLE, timeout counter 0. Reset mid-operation abandons the pending command; no pulse is emitted afterwards.
- Synchronisers: vs_udr and vs_uir each pass through SYNC_STAGES flops plus one delay flop. rise = last stage & ~delay.
- Latency: vs_udr high before edge E0 gives udr_rise during E1..E2.
  - jdo, cmd_code and state latch at E2.
  - The pulse is high during E2..E3 (SYNC_STAGES+1 edges after assertion).
  - Exactly one pulse per vs_udr rising edge, regardless of how long vs_udr stays high.
- FSM states: IDLE, DISPATCH, WAIT_ACK.
- IDLE:
  - On udr_rise: jdo<=sr, cmd_code<=ir_in, go to DISPATCH.
- DISPATCH (exactly 1 cycle):
  - take_action[cmd_code]=1 if jdo[ACT_BIT]=1, else take_no_action[cmd_code]=1. All other pulse bits 0.
  - Next state is WAIT_ACK if ACK_MASK[cmd_code]=1, else IDLE.
  - Counter cleared.
- WAIT_ACK:
  - cmd_ack=1 returns to IDLE. cmd_ack in any other state is ignored.
  - TIMEOUT_CYC>0: counter increments each cycle; at counter==TIMEOUT_CYC-1 without ack, set timeout and go to IDLE. Ack in that same cycle wins; timeout is not set.
  - Counter width: clog2(TIMEOUT_CYC+1); never wraps.
- udr_rise while state != IDLE: event dropped, jdo/cmd_code unchanged, overrun set.
- uir_rise:
  - ir_update pulses for 1 cycle in any state.
  - In WAIT_ACK it aborts to IDLE with no flag set.
  - Coincident with udr_rise in IDLE: both are processed (ir_update pulse and command latched).
- status_clr clears overrun/timeout. A set in the same cycle wins over the clear.
- jdo/cmd_code hold until the next accepted command.

Test Plan:
- Reset: reset_n=0 mid-DISPATCH -> all outputs 0 immediately; after release, no take_action pulse ever appears for the aborted command.
- Basic no-ack command: ir_in=2, sr=38'h20_0000_00AB, vs_udr high 10 cycles -> jdo=38'h20_0000_00AB, take_action=4'b0100 for exactly 1 cycle, 3 edges after assertion; busy high for 1 cycle.
- No-action: ir_in=3, sr[37]=0 -> take_no_action=4'b1000 pulse, take_action stays 0.
- Ack handshake: ir_in=0 (ACK_MASK bit set) -> busy held until cmd_ack after 50 cycles, then busy=0; second vs_udr during busy -> overrun=1, jdo unchanged; status_clr -> overrun=0.
- Timeout: TIMEOUT_CYC=8, ir_in=1, no ack -> busy drops after 8 WAIT_ACK cycles, timeout=1. Ack on cycle 8 -> timeout stays 0.
- Abort and coincidence: vs_uir during WAIT_ACK -> ir_update pulse, busy=0, no flags. vs_udr and vs_uir rising together in IDLE -> ir_update and the command pulse both occur.
